// File: rtl/alu_writeback_queue_pkg.sv
// Shared definitions for the ALU writeback queue:
// opcodes, flag bit positions, queue entry type, compare-op predicate.
package alu_writeback_queue_pkg;

  localparam int WB_DATA_W  = 32;
  localparam int WB_FLAG_W  = 8;
  localparam int WB_RADDR_W = 5;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_XOR  = 6'h04;
  localparam logic [5:0] OP_SLL  = 6'h05;
  localparam logic [5:0] OP_SRL  = 6'h06;
  localparam logic [5:0] OP_SRA  = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h09;
  localparam logic [5:0] OP_ORI  = 6'h0A;
  localparam logic [5:0] OP_CMP  = 6'h0B;
  localparam logic [5:0] OP_SUBI = 6'h0C;
  localparam logic [5:0] OP_SLT  = 6'h0D;
  localparam logic [5:0] OP_SLTU = 6'h0E;
  localparam logic [5:0] OP_CMPI = 6'h0F;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef struct packed {
    logic [WB_RADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

  // Compares only produce flags; they never write a register.
  function automatic logic is_cmp_op(input logic [5:0] op);
    return (op == OP_CMP) || (op == OP_CMPI);
  endfunction

endpackage

// File: rtl/alu_writeback_queue_if.sv
// ALU result handshake bundle into the writeback stage.
// master = ALU side, slave = writeback queue side.
interface alu_writeback_queue_if #(
  parameter int DATA_W  = 32,
  parameter int FLAG_W  = 8,
  parameter int RADDR_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_result;
  logic [FLAG_W-1:0]  in_flags;
  logic [5:0]         in_op;
  logic [RADDR_W-1:0] in_rd;
  logic               in_wb_en;

  modport master (
    output in_valid, in_result, in_flags,
    output in_op, in_rd, in_wb_en,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_result, in_flags,
    input  in_op, in_rd, in_wb_en,
    output in_ready
  );
endinterface

// File: rtl/alu_writeback_queue_wb_fifo.sv
// Circular register-write queue with explicit occupancy count.
// Storage is exposed so the parent can scan it for hazards.
module wb_fifo
  import alu_writeback_queue_pkg::*;
#(
  parameter type entry_t = wb_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH)-1:0] head_idx,
  output entry_t                   head,
  output entry_t                   entries [DEPTH]
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign push_ok  = push && (count_q != CW'(DEPTH));
  assign pop_ok   = pop && (count_q != '0);
  assign count    = count_q;
  assign head_idx = head_q;
  assign head     = mem_q[head_q];
  assign entries  = mem_q;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[tail_q] = push_data;
      tail_d        = tail_q + AW'(1);
    end
    if (pop_ok) begin
      head_d = head_q + AW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state registers; reset empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/alu_writeback_queue.sv
// Execute-to-writeback stage: commits ALU flags at once and
// queues register writes, with hazard lookup over the queue.
module alu_writeback_queue
  import alu_writeback_queue_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int FLAG_W  = WB_FLAG_W,
  parameter int RADDR_W = WB_RADDR_W,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_writeback_queue_if.slave   in_if,
  output logic [FLAG_W-1:0]      flags_q,
  output logic                   rf_we,
  output logic [RADDR_W-1:0]     rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  input  logic                   rf_ack,
  input  logic [RADDR_W-1:0]     chk_addr,
  output logic                   chk_hit,
  output logic [DATA_W-1:0]      chk_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic [DATA_W-1:0]  data;
  } entry_t;

  logic [FLAG_W-1:0] flags_d;
  logic              in_ready;
  logic              accept;
  logic              eff_wb;
  entry_t            push_data;
  entry_t            head;
  entry_t            entries [DEPTH];
  logic [AW-1:0]     head_idx;
  logic [CW-1:0]     fifo_count;

  assign in_ready       = (fifo_count != CW'(DEPTH));
  assign in_if.in_ready = in_ready;
  assign accept         = in_if.in_valid && in_ready;
  assign eff_wb         = in_if.in_wb_en
                       && (in_if.in_rd != '0)
                       && !is_cmp_op(in_if.in_op);
  assign push_data      = '{rd: in_if.in_rd, data: in_if.in_result};
  assign count          = fifo_count;

  wb_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept && eff_wb),
    .push_data (push_data),
    .pop       (rf_ack),
    .count     (fifo_count),
    .head_idx  (head_idx),
    .head      (head),
    .entries   (entries)
  );

  // Head entry drives the register-file port; zero when idle.
  always_comb begin
    rf_we    = (fifo_count != '0);
    rf_waddr = '0;
    rf_wdata = '0;
    if (rf_we) begin
      rf_waddr = head.rd;
      rf_wdata = head.data;
    end
  end

  // Arithmetic/logic ops update flags; undefined ops leave them.
  always_comb begin
    flags_d = flags_q;
    if (accept && (in_if.in_op <= OP_CMPI)) begin
      flags_d = in_if.in_flags;
    end
  end

  // Architectural flags register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    chk_hit  = 1'b0;
    chk_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((k < int'(fifo_count)) && (chk_addr != '0)
          && (entries[AW'(head_idx + AW'(k))].rd == chk_addr)) begin
        chk_hit  = 1'b1;
        chk_data = entries[AW'(head_idx + AW'(k))].data;
      end
    end
  end
endmodule

// File: tb/tb_alu_writeback_queue.sv
// Directed self-checking bench for alu_writeback_queue.
// Each task drives one scenario and checks inline.
module tb_alu_writeback_queue;
  localparam int DATA_W  = 32;
  localparam int FLAG_W  = 8;
  localparam int RADDR_W = 5;
  localparam int DEPTH   = 4;

  logic               clk;
  logic               rst;
  logic [FLAG_W-1:0]  flags_q;
  logic               rf_we;
  logic [RADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  logic               rf_ack;
  logic [RADDR_W-1:0] chk_addr;
  logic               chk_hit;
  logic [DATA_W-1:0]  chk_data;
  logic [2:0]         count;

  int vectors;
  int miscompares;

  alu_writeback_queue_if #(
    .DATA_W(DATA_W), .FLAG_W(FLAG_W), .RADDR_W(RADDR_W)
  ) bus ();

  alu_writeback_queue #(
    .DATA_W(DATA_W), .FLAG_W(FLAG_W),
    .RADDR_W(RADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_if    (bus),
    .flags_q  (flags_q),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .rf_ack   (rf_ack),
    .chk_addr (chk_addr),
    .chk_hit  (chk_hit),
    .chk_data (chk_data),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op,
                       input logic [4:0] rd, input logic [31:0] res,
                       input logic [7:0] fl, input logic wb);
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_rd     = rd;
    bus.in_result = res;
    bus.in_flags  = fl;
    bus.in_wb_en  = wb;
  endtask

  task automatic idle();
    drive(1'b0, 6'h00, 5'd0, 32'h0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rf_ack = 1'b0;
    chk_addr = '0;
    idle();
    #12;
    vectors++;
    if (flags_q !== 8'h00 || count !== 3'd0 || rf_we !== 1'b0
        || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || chk_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_vals flags=%h count=%0d we=%b addr=%0d data=%h hit=%b",
               flags_q, count, rf_we, rf_waddr, rf_wdata, chk_hit);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready got=%b want=1", bus.in_ready);
    end
  endtask

  task automatic test_single_add();
    rf_ack = 1'b1;
    drive(1'b1, 6'h00, 5'd3, 32'h0000_0005, 8'h00, 1'b1);
    tick();
    idle();
    vectors++;
    if (flags_q !== 8'h00 || rf_we !== 1'b1 || rf_waddr !== 5'd3
        || rf_wdata !== 32'd5 || count !== 3'd1) begin
      miscompares++;
      $display("FAIL add_write flags=%h we=%b addr=%0d data=%h count=%0d want 00 1 3 5 1",
               flags_q, rf_we, rf_waddr, rf_wdata, count);
    end
    tick();
    vectors++;
    if (rf_we !== 1'b0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL add_retire we=%b count=%0d want 0 0", rf_we, count);
    end
  endtask

  task automatic test_cmp();
    rf_ack = 1'b1;
    drive(1'b1, 6'h0B, 5'd4, 32'h0000_1234, 8'h02, 1'b1);
    tick();
    idle();
    vectors++;
    if (flags_q !== 8'h02 || rf_we !== 1'b0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL cmp_noenq flags=%h we=%b count=%0d want 02 0 0",
               flags_q, rf_we, count);
    end
    drive(1'b1, 6'h10, 5'd4, 32'h0000_1234, 8'h05, 1'b1);
    tick();
    idle();
    vectors++;
    if (flags_q !== 8'h02 || rf_we !== 1'b1 || rf_waddr !== 5'd4
        || rf_wdata !== 32'h1234 || count !== 3'd1) begin
      miscompares++;
      $display("FAIL op10_enq flags=%h we=%b addr=%0d data=%h count=%0d want 02 1 4 1234 1",
               flags_q, rf_we, rf_waddr, rf_wdata, count);
    end
    tick();
    drive(1'b1, 6'h00, 5'd0, 32'h0000_00FF, 8'h08, 1'b1);
    tick();
    idle();
    vectors++;
    if (flags_q !== 8'h08 || rf_we !== 1'b0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL rd0_noenq flags=%h we=%b count=%0d want 08 0 0",
               flags_q, rf_we, count);
    end
    drive(1'b1, 6'h0F, 5'd6, 32'h0000_0001, 8'h01, 1'b1);
    tick();
    drive(1'b1, 6'h01, 5'd6, 32'h0000_0009, 8'h04, 1'b0);
    tick();
    idle();
    vectors++;
    if (flags_q !== 8'h04 || rf_we !== 1'b0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL cmpi_nowb flags=%h we=%b count=%0d want 04 0 0",
               flags_q, rf_we, count);
    end
  endtask

  task automatic test_full_wrap();
    logic drop;
    rf_ack = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 6'h00, 5'(i), 32'h100 + 32'(i), 8'h00, 1'b1);
      tick();
    end
    vectors++;
    if (bus.in_ready !== 1'b0 || count !== 3'd4) begin
      miscompares++;
      $display("FAIL full_hold ready=%b count=%0d want 0 4", bus.in_ready, count);
    end
    rf_ack = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      vectors++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(j)
          || rf_wdata !== 32'h100 + 32'(j)) begin
        miscompares++;
        $display("FAIL drain_order step=%0d we=%b addr=%0d data=%h want rd=%0d",
                 j, rf_we, rf_waddr, rf_wdata, j);
      end
      drop = bus.in_valid && bus.in_ready;
      tick();
      if (drop) idle();
    end
    vectors++;
    if (count !== 3'd0 || rf_we !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty count=%0d we=%b want 0 0", count, rf_we);
    end
  endtask

  task automatic test_hazard();
    rf_ack = 1'b0;
    drive(1'b1, 6'h00, 5'd7, 32'h0000_AAAA, 8'h00, 1'b1);
    tick();
    drive(1'b1, 6'h00, 5'd7, 32'h0000_BBBB, 8'h00, 1'b1);
    tick();
    drive(1'b1, 6'h00, 5'd9, 32'h0000_CCCC, 8'h00, 1'b1);
    tick();
    idle();
    chk_addr = 5'd7;
    #1;
    vectors++;
    if (chk_hit !== 1'b1 || chk_data !== 32'hBBBB) begin
      miscompares++;
      $display("FAIL hz_youngest hit=%b data=%h want 1 BBBB", chk_hit, chk_data);
    end
    chk_addr = 5'd0;
    #1;
    vectors++;
    if (chk_hit !== 1'b0 || chk_data !== 32'h0) begin
      miscompares++;
      $display("FAIL hz_r0 hit=%b data=%h want 0 0", chk_hit, chk_data);
    end
    chk_addr = 5'd10;
    #1;
    vectors++;
    if (chk_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL hz_miss hit=%b want 0", chk_hit);
    end
    rf_ack = 1'b1;
    tick();
    tick();
    chk_addr = 5'd9;
    #1;
    vectors++;
    if (chk_hit !== 1'b1 || chk_data !== 32'hCCCC || rf_we !== 1'b1) begin
      miscompares++;
      $display("FAIL hz_popping hit=%b data=%h we=%b want 1 CCCC 1",
               chk_hit, chk_data, rf_we);
    end
    chk_addr = 5'd7;
    #1;
    vectors++;
    if (chk_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL hz_retired hit=%b want 0", chk_hit);
    end
    tick();
    chk_addr = 5'd9;
    #1;
    vectors++;
    if (chk_hit !== 1'b0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL hz_empty hit=%b count=%0d want 0 0", chk_hit, count);
    end
    chk_addr = '0;
  endtask

  task automatic test_full_pop_push();
    rf_ack = 1'b0;
    for (int i = 11; i <= 14; i++) begin
      drive(1'b1, 6'h00, 5'(i), 32'h200 + 32'(i), 8'h00, 1'b1);
      tick();
    end
    drive(1'b1, 6'h00, 5'd15, 32'h0000_0215, 8'h00, 1'b1);
    rf_ack = 1'b1;
    #1;
    vectors++;
    if (count !== 3'd4 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fpp_full count=%0d ready=%b want 4 0", count, bus.in_ready);
    end
    tick();
    rf_ack = 1'b0;
    vectors++;
    if (count !== 3'd3 || bus.in_ready !== 1'b1 || rf_waddr !== 5'd12) begin
      miscompares++;
      $display("FAIL fpp_pop count=%0d ready=%b head=%0d want 3 1 12",
               count, bus.in_ready, rf_waddr);
    end
    tick();
    idle();
    chk_addr = 5'd15;
    #1;
    vectors++;
    if (count !== 3'd4 || chk_hit !== 1'b1 || chk_data !== 32'h215) begin
      miscompares++;
      $display("FAIL fpp_push count=%0d hit=%b data=%h want 4 1 215",
               count, chk_hit, chk_data);
    end
    chk_addr = '0;
    rf_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (count !== 3'd0) begin
      miscompares++;
      $display("FAIL fpp_drain count=%0d want 0", count);
    end
  endtask

  task automatic test_reset_mid();
    bit seen_we;
    rf_ack = 1'b0;
    for (int i = 20; i <= 22; i++) begin
      drive(1'b1, 6'h00, 5'(i), 32'h300 + 32'(i), 8'h0F, 1'b1);
      tick();
    end
    idle();
    vectors++;
    if (count !== 3'd3 || rf_we !== 1'b1 || flags_q !== 8'h0F) begin
      miscompares++;
      $display("FAIL mid_setup count=%0d we=%b flags=%h want 3 1 0F",
               count, rf_we, flags_q);
    end
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (rf_we !== 1'b0 || count !== 3'd0 || flags_q !== 8'h00
        || rf_waddr !== 5'd0) begin
      miscompares++;
      $display("FAIL mid_async we=%b count=%0d flags=%h addr=%0d want 0 0 00 0",
               rf_we, count, flags_q, rf_waddr);
    end
    @(negedge clk);
    rst = 1'b0;
    rf_ack = 1'b1;
    seen_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rf_we !== 1'b0) seen_we = 1'b1;
    end
    vectors++;
    if (seen_we || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_after stray_we=%b ready=%b want 0 1",
               seen_we, bus.in_ready);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_add();
    test_cmp();
    test_full_wrap();
    test_hazard();
    test_full_pop_push();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_writeback_queue.md
Name: alu_writeback_queue

Overview:
Execute-to-writeback stage directly downstream of the 32-bit ALU.
- Accepts each ALU result with its flags, op and destination register.
- Commits architectural flags immediately, and feeds them back as the ALU's flags_in.
- Buffers register-file writes in a small FIFO so a stalled register-file port does not stall the flag path.
- Supplies hazard-detect and forwarding data for queued, not-yet-written destinations.

Parameters:
DATA_W, 32, result/write data width
FLAG_W, 8, flags width (bit0 carry, bit1 zero, bit2 negative, bit3 overflow)
RADDR_W, 5, register address width
DEPTH, 4, queue entries; power of two, minimum 2

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  ALU output valid
in_ready  out  1  stage can accept
in_result  in  DATA_W  ALU result
in_flags  in  FLAG_W  ALU flags_out
in_op  in  6  ALU opcode of this result
in_rd  in  RADDR_W  destination register
in_wb_en  in  1  instruction writes rd
flags_q  out  FLAG_W  architectural flags register (to ALU flags_in)
rf_we  out  1  register-file write request
rf_waddr  out  RADDR_W  write address
rf_wdata  out  DATA_W  write data
rf_ack  in  1  register file accepted head write this cycle
chk_addr  in  RADDR_W  source register being read by issue
chk_hit  out  1  chk_addr has a pending queued write
chk_data  out  DATA_W  youngest pending data for chk_addr
count  out  clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (async assert) values:
  - flags_q=0, count=0, rf_we=0, rf_waddr=0, rf_wdata=0, chk_hit=0.
  - in_ready=1 from the first cycle after rst deasserts.
  - Reset mid-operation discards all queued entries; no write is issued for them.
- Accept: in_valid && in_ready. in_ready = (count != DEPTH). in_ready does not depend on rf_ack or in_op, so there is no combinational ack-to-ready path.
- Flags: on accept, flags_q <= in_flags when in_op <= 6'h0F. Ops above 6'h0F (ALU default case) leave flags_q unchanged. Flags update even when no register write is enqueued.
- Effective write enable: eff_wb = in_wb_en && in_rd != 0 && in_op not in {6'h0B CMP, 6'h0F CMPI}.
  - Accepted beats with eff_wb=0 are consumed and not enqueued.
- Enqueue: accepted beat with eff_wb=1 writes {rd, result} at the tail; tail pointer wraps modulo DEPTH.
- Write port:
  - rf_we = (count != 0); rf_waddr/rf_wdata are the head entry, driven from registered storage.
  - Head pops on rf_we && rf_ack; the next entry is presented the following cycle.
  - rf_ack while rf_we=0 is ignored.
- Latency: a beat accepted at edge N with an empty queue gives rf_we=1 during cycle N+1; one entry retires per cycle with continuous rf_ack.
- Simultaneous push and pop: count unchanged, pointers both advance. When full, push is blocked even if pop occurs that cycle.
- Full/empty: count==DEPTH means full; count==0 means empty. Pointers carry an extra wrap bit, or count is kept explicitly; overflow and underflow are impossible by construction.
- Hazard check (combinational over valid entries):
  - chk_hit=1 iff chk_addr!=0 and some valid entry has rd==chk_addr.
  - chk_data = data of the youngest matching entry (closest to tail), else 0.
  - An entry popping this cycle still counts as a hit this cycle.
  - The incoming beat is not included; issue forwards from the ALU output itself.

Decomposition:
- Shared package:
  - ALU opcode localparams (ADD..CMPI, 6'h00–6'h0F).
  - Flag bit positions.
  - A writeback entry struct {rd, data}.
  - The compare-op predicate function.
- One sub-module: wb_fifo, a parameterised DEPTH×(RADDR_W+DATA_W) queue with push/pop/count and an exposed entry array for the hazard scan. The flags register and eff_wb logic stay in the top module.

Test Plan:
- Reset then single ADD (rd=3, result=0x0000_0005, flags=0x00, wb_en=1) with rf_ack held 1 -> flags_q=0x00 next cycle; rf_we=1, rf_waddr=3, rf_wdata=5 for exactly one cycle; count returns 0.
- CMP (op=0x0B, rd=4, wb_en=1, flags=0x02) -> flags_q=0x02; no rf_we; count stays 0. Same beat with op=0x10 -> flags_q unchanged, write enqueued.
- rf_ack=0, push 5 writes rd=1..5 (DEPTH=4) -> in_ready=0 after the 4th; the 5th is held. Release rf_ack -> writes rd1..rd4 in order, then rd5; pointers wrap correctly.
- Queue holds rd=7:0xAAAA then rd=7:0xBBBB, chk_addr=7 -> chk_hit=1, chk_data=0xBBBB. chk_addr=0 -> chk_hit=0.
- Full queue, rf_ack=1, in_valid=1 same cycle -> one pop and no push; next cycle in_ready=1 and the push is accepted; count sequence 4,3,4.
- Assert rst mid-stream with count=3 and rf_we=1 -> rf_we=0, count=0, flags_q=0 immediately (async); no further writes after release.
